// File: rtl/conv_layer_scheduler_if.sv
// Bus bundle between the layer scheduler, its conv engine, bias memory and output buffer.
// Signal names are from the scheduler's point of view: i_* flow into it, o_* flow out.
interface conv_layer_scheduler_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int NUMBER_OF_FILTER = 4,
    parameter int OUT_PIXELS       = 9
);
    localparam int FW = (NUMBER_OF_FILTER > 1) ? $clog2(NUMBER_OF_FILTER) : 1;
    localparam int AW = (NUMBER_OF_FILTER * OUT_PIXELS > 1) ? $clog2(NUMBER_OF_FILTER * OUT_PIXELS) : 1;

    logic                  i_start;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic                  o_bias_rd_en;
    logic [FW-1:0]         o_bias_rd_addr;
    logic [DATA_WIDTH-1:0] i_bias_rd_data;
    logic                  o_conv_valid;
    logic [DATA_WIDTH-1:0] o_conv_bias;
    logic [FW-1:0]         o_conv_kernel_sel;
    logic [DATA_WIDTH-1:0] i_conv_data;
    logic                  i_conv_valid;
    logic                  o_wr_en;
    logic [AW-1:0]         o_wr_addr;
    logic [DATA_WIDTH-1:0] o_wr_data;

    modport master (
        input  i_start, i_bias_rd_data, i_conv_data, i_conv_valid,
        output o_busy, o_done, o_error, o_bias_rd_en, o_bias_rd_addr,
               o_conv_valid, o_conv_bias, o_conv_kernel_sel,
               o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        output i_start, i_bias_rd_data, i_conv_data, i_conv_valid,
        input  o_busy, o_done, o_error, o_bias_rd_en, o_bias_rd_addr,
               o_conv_valid, o_conv_bias, o_conv_kernel_sel,
               o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/conv_layer_scheduler.sv
// Runs one conv layer through a shared 3x3xC engine, one output filter at a time:
// bias fetch, engine start, pixel collection into the output buffer, with a no-progress timeout.
module conv_layer_scheduler #(
    parameter int DATA_WIDTH       = 32,
    parameter int NUMBER_OF_FILTER = 4,
    parameter int OUT_PIXELS       = 9,
    parameter int GAP_CYCLES       = 2,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv_layer_scheduler_if.master bus
);
    localparam int FW = (NUMBER_OF_FILTER > 1) ? $clog2(NUMBER_OF_FILTER) : 1;
    localparam int AW = (NUMBER_OF_FILTER * OUT_PIXELS > 1) ? $clog2(NUMBER_OF_FILTER * OUT_PIXELS) : 1;
    localparam int PW = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [FW-1:0] LAST_FILTER = FW'(NUMBER_OF_FILTER - 1);
    localparam logic [PW-1:0] LAST_PIXEL  = PW'(OUT_PIXELS - 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_LAST    = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_GAP   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         filter_q, filter_d;
    logic [PW-1:0]         pix_q, pix_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [TW-1:0]         timeout_q, timeout_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [DATA_WIDTH-1:0] bias_q, bias_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  bias_rd_en_q, bias_rd_en_d;
    logic                  conv_valid_q, conv_valid_d;
    logic                  wr_en_q, wr_en_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [TW-1:0]         timeout_inc_s;

    // Next-state and datapath updates; every output is registered from its _d value.
    always_comb begin
        state_d       = state_q;
        filter_d      = filter_q;
        pix_d         = pix_q;
        addr_d        = addr_q;
        timeout_d     = timeout_q;
        gap_d         = gap_q;
        bias_d        = bias_q;
        error_d       = error_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        timeout_inc_s = timeout_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    filter_d = '0;
                    addr_d   = '0;
                    error_d  = 1'b0;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                bias_d  = bus.i_bias_rd_data;
                state_d = S_START;
            end
            S_START: begin
                pix_d     = '0;
                timeout_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (bus.i_conv_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = bus.i_conv_data;
                    timeout_d = '0;
                    if (pix_q == LAST_PIXEL) begin
                        pix_d = '0;
                        // The final address is held rather than stepped past the buffer end.
                        if (filter_q == LAST_FILTER) begin
                            state_d = S_DONE;
                        end else begin
                            filter_d = filter_q + FW'(1);
                            addr_d   = addr_q + AW'(1);
                            gap_d    = '0;
                            state_d  = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
                        end
                    end else begin
                        pix_d  = pix_q + PW'(1);
                        addr_d = addr_q + AW'(1);
                    end
                end else if (timeout_inc_s == TIMEOUT_VAL) begin
                    timeout_d = timeout_inc_s;
                    error_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timeout_d = timeout_inc_s;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d != S_IDLE);
        bias_rd_en_d = (state_d == S_FETCH);
        conv_valid_d = (state_d == S_START);
        done_d       = (state_d == S_DONE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            filter_q     <= '0;
            pix_q        <= '0;
            addr_q       <= '0;
            timeout_q    <= '0;
            gap_q        <= '0;
            bias_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            bias_rd_en_q <= 1'b0;
            conv_valid_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            filter_q     <= filter_d;
            pix_q        <= pix_d;
            addr_q       <= addr_d;
            timeout_q    <= timeout_d;
            gap_q        <= gap_d;
            bias_q       <= bias_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            bias_rd_en_q <= bias_rd_en_d;
            conv_valid_q <= conv_valid_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.o_busy            = busy_q;
    assign bus.o_done            = done_q;
    assign bus.o_error           = error_q;
    assign bus.o_bias_rd_en      = bias_rd_en_q;
    assign bus.o_bias_rd_addr    = filter_q;
    assign bus.o_conv_valid      = conv_valid_q;
    assign bus.o_conv_bias       = bias_q;
    assign bus.o_conv_kernel_sel = filter_q;
    assign bus.o_wr_en           = wr_en_q;
    assign bus.o_wr_addr         = wr_addr_q;
    assign bus.o_wr_data         = wr_data_q;
endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: behavioural bias memory and conv engine
// (latency 10, 9 pixels per start), a write/start logger, and a linear check sequence.
module tb_conv_layer_scheduler;
    localparam logic [31:0] BIAS [4] = '{32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h0000_0000};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    conv_layer_scheduler_if #(.DATA_WIDTH(32), .NUMBER_OF_FILTER(4), .OUT_PIXELS(9)) bus ();

    conv_layer_scheduler #(
        .DATA_WIDTH(32), .NUMBER_OF_FILTER(4), .OUT_PIXELS(9),
        .GAP_CYCLES(2), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pix_val(input int k, input int p);
        return 32'h3F00_0000 + 32'(k * 256 + p);
    endfunction

    // Bias memory: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.o_bias_rd_en) bus.i_bias_rd_data <= BIAS[bus.o_bias_rd_addr];
    end

    // Engine model: pixels p=0..8 of kernel k appear 10..18 cycles after the start pulse.
    int          eng_t, eng_k, eng_served, eng_limit;
    logic        eng_valid, stray_valid;
    logic [31:0] eng_data;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_t <= 0; eng_k <= 0; eng_served <= 0; eng_valid <= 1'b0; eng_data <= 32'h0;
        end else if (bus.o_conv_valid && (eng_served < eng_limit)) begin
            eng_t <= 1; eng_k <= int'(bus.o_conv_kernel_sel); eng_served <= eng_served + 1;
            eng_valid <= 1'b0;
        end else if (eng_t != 0) begin
            if (eng_t >= 9 && eng_t <= 17) begin
                eng_valid <= 1'b1; eng_data <= pix_val(eng_k, eng_t - 9);
            end else begin
                eng_valid <= 1'b0;
            end
            eng_t <= (eng_t == 18) ? 0 : eng_t + 1;
        end else begin
            eng_valid <= 1'b0;
        end
    end
    assign bus.i_conv_valid = eng_valid | stray_valid;
    assign bus.i_conv_data  = stray_valid ? 32'hDEAD_BEEF : eng_data;

    // Logger of buffer writes, engine starts and done pulses.
    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];
    logic [31:0] sq_sel  [$];
    logic [31:0] sq_bias [$];
    int          done_cnt;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= done_cnt;
        end else begin
            if (bus.o_wr_en) begin wq_addr.push_back(32'(bus.o_wr_addr)); wq_data.push_back(bus.o_wr_data); end
            if (bus.o_conv_valid) begin sq_sel.push_back(32'(bus.o_conv_kernel_sel)); sq_bias.push_back(bus.o_conv_bias); end
            if (bus.o_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        bus.i_start = 1'b1; tick(); bus.i_start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
        chk({tag, "_error"}, 32'(bus.o_error), 32'd0);
        chk({tag, "_rd_en"}, 32'(bus.o_bias_rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(bus.o_bias_rd_addr), 32'd0);
        chk({tag, "_conv_valid"}, 32'(bus.o_conv_valid), 32'd0);
        chk({tag, "_conv_bias"}, bus.o_conv_bias, 32'd0);
        chk({tag, "_kernel_sel"}, 32'(bus.o_conv_kernel_sel), 32'd0);
        chk({tag, "_wr_en"}, 32'(bus.o_wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(bus.o_wr_addr), 32'd0);
        chk({tag, "_wr_data"}, bus.o_wr_data, 32'd0);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (bus.o_done) break;
            tick();
        end
        chk({tag, "_done_seen"}, 32'(bus.o_done), 32'd1);
        tick();
        chk({tag, "_busy_after_done"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_done_one_cycle"}, 32'(bus.o_done), 32'd0);
    endtask

    task automatic verify_layer(input string tag, input int wb, input int sb, input int nw, input int ns);
        chk({tag, "_nwrites"}, 32'(wq_addr.size() - wb), 32'(nw));
        for (int i = 0; i < nw && (wb + i) < wq_addr.size(); i++) begin
            chk($sformatf("%s_wr_addr%0d", tag, i), wq_addr[wb + i], 32'(i));
            chk($sformatf("%s_wr_data%0d", tag, i), wq_data[wb + i], pix_val(i / 9, i % 9));
        end
        chk({tag, "_nstarts"}, 32'(sq_sel.size() - sb), 32'(ns));
        for (int k = 0; k < ns && (sb + k) < sq_sel.size(); k++) begin
            chk($sformatf("%s_kernel_sel%0d", tag, k), sq_sel[sb + k], 32'(k));
            chk($sformatf("%s_bias%0d", tag, k), sq_bias[sb + k], BIAS[k]);
        end
    endtask

    int wb, sb, db;

    initial begin
        clk = 1'b0; rst_n = 1'b0; checks = 0; errors = 0; done_cnt = 0;
        bus.i_start = 1'b0; stray_valid = 1'b0; eng_limit = 1000;
        repeat (3) tick();
        chk_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Nominal layer with cycle-exact timing probes; cycle t is the start cycle.
        wb = wq_addr.size(); sb = sq_sel.size(); db = done_cnt;
        do_start();                                             // now t+1
        chk("t1_busy", 32'(bus.o_busy), 32'd1);
        chk("t1_rd_en", 32'(bus.o_bias_rd_en), 32'd1);
        chk("t1_rd_addr", 32'(bus.o_bias_rd_addr), 32'd0);
        tick();                                                 // t+2
        chk("t2_rd_en", 32'(bus.o_bias_rd_en), 32'd0);
        chk("t2_conv_valid", 32'(bus.o_conv_valid), 32'd0);
        tick();                                                 // t+3
        chk("t3_conv_valid", 32'(bus.o_conv_valid), 32'd1);
        chk("t3_conv_bias", bus.o_conv_bias, 32'h3F80_0000);
        chk("t3_kernel_sel", 32'(bus.o_conv_kernel_sel), 32'd0);
        tick();                                                 // t+4
        chk("t4_conv_valid", 32'(bus.o_conv_valid), 32'd0);
        repeat (9) tick();                                      // t+13: first pixel arrives
        chk("t13_pixel_in", 32'(bus.i_conv_valid), 32'd1);
        chk("t13_wr_en", 32'(bus.o_wr_en), 32'd0);
        tick();                                                 // t+14: first write
        chk("t14_wr_en", 32'(bus.o_wr_en), 32'd1);
        chk("t14_wr_addr", 32'(bus.o_wr_addr), 32'd0);
        chk("t14_wr_data", bus.o_wr_data, pix_val(0, 0));
        repeat (9) tick();                                      // t+23: last pixel at t+21, gap
        chk("t23_rd_en", 32'(bus.o_bias_rd_en), 32'd0);
        chk("t23_busy", 32'(bus.o_busy), 32'd1);
        tick();                                                 // t+24: next fetch
        chk("t24_rd_en", 32'(bus.o_bias_rd_en), 32'd1);
        chk("t24_rd_addr", 32'(bus.o_bias_rd_addr), 32'd1);
        chk("t24_kernel_sel", 32'(bus.o_conv_kernel_sel), 32'd1);
        wait_done("nom");
        verify_layer("nom", wb, sb, 36, 4);
        chk("nom_done_count", 32'(done_cnt - db), 32'd1);

        // Robustness: stray pixels in IDLE and GAP, start pulse during RUN.
        stray_valid = 1'b1; tick(); stray_valid = 1'b0;
        tick();
        chk("idle_stray_wr_en", 32'(bus.o_wr_en), 32'd0);
        chk("idle_stray_busy", 32'(bus.o_busy), 32'd0);
        wb = wq_addr.size(); sb = sq_sel.size(); db = done_cnt;
        do_start();
        for (int i = 0; i < 100; i++) begin
            if (bus.o_wr_en && bus.o_wr_addr == 6'd8) break;
            tick();
        end
        chk("rob_last_px_f0", 32'(bus.o_wr_addr), 32'd8);
        stray_valid = 1'b1; tick(); stray_valid = 1'b0;        // stray pixel during GAP
        chk("gap_stray_wr_en", 32'(bus.o_wr_en), 32'd0);
        chk("gap_rd_en", 32'(bus.o_bias_rd_en), 32'd0);
        tick();
        chk("gap_fetch", 32'(bus.o_bias_rd_en), 32'd1);
        repeat (8) tick();                                      // filter 1 in RUN
        do_start();
        chk("run_start_busy", 32'(bus.o_busy), 32'd1);
        chk("run_start_rd_en", 32'(bus.o_bias_rd_en), 32'd0);
        chk("run_start_kernel_sel", 32'(bus.o_conv_kernel_sel), 32'd1);
        wait_done("rob");
        verify_layer("rob", wb, sb, 36, 4);
        chk("rob_done_count", 32'(done_cnt - db), 32'd1);

        // Timeout: engine answers only the first start.
        wb = wq_addr.size(); sb = sq_sel.size(); db = done_cnt;
        eng_limit = eng_served + 1;
        do_start();
        for (int i = 0; i < 200; i++) begin
            if (bus.o_conv_valid && bus.o_conv_kernel_sel == 2'd1) break;
            tick();
        end
        chk("to_second_start", 32'(bus.o_conv_valid), 32'd1);
        repeat (1024) tick();
        chk("to_error_not_yet", 32'(bus.o_error), 32'd0);
        chk("to_busy_not_yet", 32'(bus.o_busy), 32'd1);
        tick();
        chk("to_error", 32'(bus.o_error), 32'd1);
        chk("to_busy", 32'(bus.o_busy), 32'd0);
        repeat (3) tick();
        chk("to_error_sticky", 32'(bus.o_error), 32'd1);
        chk("to_no_done", 32'(done_cnt - db), 32'd0);
        verify_layer("to", wb, sb, 9, 2);
        eng_limit = 1000;
        wb = wq_addr.size(); sb = sq_sel.size(); db = done_cnt;
        do_start();
        chk("to_error_cleared", 32'(bus.o_error), 32'd0);
        wait_done("after_to");
        verify_layer("after_to", wb, sb, 36, 4);

        // Reset in the middle of filter 2.
        do_start();
        for (int i = 0; i < 200; i++) begin
            if (bus.o_conv_valid && bus.o_conv_kernel_sel == 2'd2) break;
            tick();
        end
        repeat (12) tick();
        chk("pre_rst_wr_en", 32'(bus.o_wr_en), 32'd1);
        db = done_cnt;
        rst_n = 1'b0; #1;
        chk_all_zero("mid_rst");
        repeat (2) tick();
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("post_rst_no_done", 32'(done_cnt - db), 32'd0);
        wb = wq_addr.size(); sb = sq_sel.size(); db = done_cnt;
        do_start();
        chk("post_rst_rd_addr", 32'(bus.o_bias_rd_addr), 32'd0);
        wait_done("post_rst");
        verify_layer("post_rst", wb, sb, 36, 4);
        chk("post_rst_done_count", 32'(done_cnt - db), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
